branch_jump_predict: RTL
========================

BRANCH_JUMP_PREDICT -- requirements
Module: branch_jump_predict

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width; SHALL be 32 or 64.
REQ-002 Parameter BHT_DEPTH, default 64: number of 2-bit counters; SHALL be a power of two, at least 2.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_fetch_pc  input  XLEN  fetch-stage PC used for prediction lookup.
REQ-006 o_pred_taken  output  1  combinational prediction for i_fetch_pc.
REQ-007 i_valid  input  1  resolve request qualifier.
REQ-008 i_Branch  input  1  instruction is a conditional branch.
REQ-009 i_Jump  input  1  instruction is a jump.
REQ-010 i_Funct3  input  3  branch condition select.
REQ-011 i_rs1, i_rs2  input  XLEN  compare operands.
REQ-012 i_pc  input  XLEN  PC of the resolving instruction.
REQ-013 i_pred_taken  input  1  prediction carried with the resolving instruction.
REQ-014 o_valid  output  1  registered resolve-result strobe.
REQ-015 o_B_J_result  output  2  00 sequential, 01 PC-relative redirect, 11 register-target redirect.
REQ-016 o_mispredict  output  1  resolved branch direction differs from i_pred_taken.
REQ-017 o_mispredict_cnt  output  32  saturating mispredict count.

Function
REQ-018 Index: PC[log2(BHT_DEPTH)+1:2]; bits [1:0] ignored.
REQ-019 o_pred_taken SHALL equal bit 1 of counter[index(i_fetch_pc)], zero-cycle latency.
REQ-020 Branch taken: funct3 000 equal; 001 not equal; 100 signed less-than; 101 signed greater-or-equal; 110 unsigned less-than; 111 unsigned greater-or-equal; 010/011 never taken (illegal).
REQ-021 Resolve latency SHALL be 1 cycle: on the edge where i_valid=1, o_valid, o_B_J_result and o_mispredict are registered; with i_valid=0, o_valid=0 and the other two outputs are 00/0.
REQ-022 {i_Jump,i_Branch} SHALL decode as 01 -> 01 if taken, else 00; 10 -> 01; 11 -> 11; 00 -> 00.
REQ-023 o_mispredict=1 only for {i_Jump,i_Branch}=01 with legal funct3 and taken != i_pred_taken.
REQ-024 On a valid, legal branch, counter[index(i_pc)] SHALL saturate-increment if taken, saturate-decrement if not taken; 11 and 00 hold.
REQ-025 Jumps, illegal funct3 and i_valid=0 SHALL not modify the table.
REQ-026 If the lookup index equals the update index in the same cycle, o_pred_taken SHALL reflect the pre-update value.
REQ-027 o_mispredict_cnt increments on each registered mispredict and holds at 0xFFFFFFFF.

Reset
REQ-028 With i_rst=1 at an edge: all counters = 01, o_valid=0, o_B_J_result=00, o_mispredict=0, o_mispredict_cnt=0; inputs that edge are discarded.
REQ-029 Reset mid-operation SHALL drop any in-flight resolve; no table update occurs in that cycle.

Configuration
REQ-030 Macro BJ_PREDICT_BHT_EN defined: BHT per REQ-018..026.
REQ-031 Macro BJ_PREDICT_BHT_EN undefined: no table storage; o_pred_taken tied to 0; branch mispredict = taken; REQ-021..023 and REQ-027 unchanged.

Verification
REQ-032 Reset, then fetch PC 0x100 -> o_pred_taken=0 (counter 01).
REQ-033 Branch funct3=000, rs1=rs2=5, pc=0x100, pred=0 -> next cycle o_B_J_result=01, o_mispredict=1, cnt=1; fetch 0x100 then predicts 1.
REQ-034 funct3=100, rs1=0xFFFFFFFF, rs2=1 -> taken; funct3=110, same operands -> not taken, result 00.
REQ-035 Three taken resolves at 0x200, then one not-taken -> counter 11 then 10; prediction stays 1.
REQ-036 {i_Jump,i_Branch}=11 -> 11, =10 -> 01; no mispredict, table unchanged; i_rst asserted during a valid branch -> outputs zero, counter stays 01.

Source files
------------

// File: rtl/branch_jump_predict_if.sv
// Resolve/predict bus for branch_jump_predict.
// master: fetch/execute side driving requests; slave: the predictor itself.
interface branch_jump_predict_if #(
    parameter int XLEN = 32
);
    // prediction lookup
    logic [XLEN-1:0] i_fetch_pc;
    logic            o_pred_taken;
    // resolve request
    logic            i_valid;
    logic            i_Branch;
    logic            i_Jump;
    logic [2:0]      i_Funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [XLEN-1:0] i_pc;
    logic            i_pred_taken;
    // resolve result
    logic            o_valid;
    logic [1:0]      o_B_J_result;
    logic            o_mispredict;
    logic [31:0]     o_mispredict_cnt;

    modport master (
        output i_fetch_pc, i_valid, i_Branch, i_Jump, i_Funct3,
               i_rs1, i_rs2, i_pc, i_pred_taken,
        input  o_pred_taken, o_valid, o_B_J_result, o_mispredict, o_mispredict_cnt
    );

    modport slave (
        input  i_fetch_pc, i_valid, i_Branch, i_Jump, i_Funct3,
               i_rs1, i_rs2, i_pc, i_pred_taken,
        output o_pred_taken, o_valid, o_B_J_result, o_mispredict, o_mispredict_cnt
    );
endinterface

// File: rtl/branch_jump_predict.sv
// Branch/jump resolver with optional 2-bit bimodal direction predictor.
// Optional feature macro: BJ_PREDICT_BHT_EN
//   defined   -> BHT_DEPTH 2-bit counters indexed by PC[log2(BHT_DEPTH)+1:2]
//   undefined -> no table, prediction is always not-taken
// Resolve results are registered (1-cycle latency); reset is synchronous, active-high.
module branch_jump_predict #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input logic                  i_clk,
    input logic                  i_rst,
    branch_jump_predict_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    if ((XLEN != 32 && XLEN != 64) || BHT_DEPTH < 2 ||
        (BHT_DEPTH & (BHT_DEPTH - 1)) != 0) begin : g_bad_params
        $error("branch_jump_predict: XLEN must be 32/64, BHT_DEPTH a power of two >= 2");
    end

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            br_taken;
    logic            funct3_legal;
    logic            branch_legal;
    logic [1:0]      result_d;
    logic            mispredict_d;

    logic            valid_q;
    logic [1:0]      result_q;
    logic            mispredict_q;
    logic [31:0]     mispredict_cnt_q;

    assign rs1 = bus.i_rs1;
    assign rs2 = bus.i_rs2;

    // Branch condition evaluation; illegal funct3 encodings are never taken.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        br_taken     = 1'b0;
        funct3_legal = 1'b1;
        case (bus.i_Funct3)
            3'b000:  br_taken = (rs1 == rs2);
            3'b001:  br_taken = (rs1 != rs2);
            3'b100:  br_taken = ($signed(rs1) <  $signed(rs2));
            3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  br_taken = (rs1 <  rs2);
            3'b111:  br_taken = (rs1 >= rs2);
            default: funct3_legal = 1'b0;
        endcase
    end

    // Only a valid, pure conditional branch with a legal condition trains/mispredicts.
    assign branch_legal = bus.i_valid & ~bus.i_Jump & bus.i_Branch & funct3_legal;

    // Redirect-type decode from {jump, branch}.
    always_comb begin
        result_d = 2'b00;
        case ({bus.i_Jump, bus.i_Branch})
            2'b01:   result_d = br_taken ? 2'b01 : 2'b00;
            2'b10:   result_d = 2'b01;
            2'b11:   result_d = 2'b11;
            default: result_d = 2'b00;
        endcase
    end

`ifdef BJ_PREDICT_BHT_EN
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign fetch_idx    = bus.i_fetch_pc[IDX_W+1:2];
    assign upd_idx      = bus.i_pc[IDX_W+1:2];
    assign mispredict_d = branch_legal & (br_taken != bus.i_pred_taken);

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign bus.o_pred_taken = bht[fetch_idx][1];

    assign unused_pc_bits = ^{bus.i_fetch_pc[XLEN-1:IDX_W+2], bus.i_fetch_pc[1:0],
                              bus.i_pc[XLEN-1:IDX_W+2], bus.i_pc[1:0]};

    // Saturating 2-bit counter training on resolved legal branches.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the table is built from flops, not RAM, so a reset loop over every entry is legal here.
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (branch_legal) begin
            if (br_taken && bht[upd_idx] != 2'b11) begin
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            end else if (!br_taken && bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end
`else
    logic unused_pred_inputs;

    // Without a table every branch is predicted not-taken, so any taken branch mispredicts.
    assign mispredict_d       = branch_legal & br_taken;
    assign bus.o_pred_taken   = 1'b0;
    assign unused_pred_inputs = ^{bus.i_fetch_pc, bus.i_pc, bus.i_pred_taken};
`endif

    // Registered resolve result and saturating mispredict counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q          <= 1'b0;
            result_q         <= 2'b00;
            mispredict_q     <= 1'b0;
            mispredict_cnt_q <= 32'd0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            valid_q      <= bus.i_valid;
            result_q     <= bus.i_valid ? result_d : 2'b00;
            mispredict_q <= mispredict_d;
            if (mispredict_d && mispredict_cnt_q != 32'hFFFF_FFFF) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bus.o_valid          = valid_q;
    assign bus.o_B_J_result     = result_q;
    assign bus.o_mispredict     = mispredict_q;
    assign bus.o_mispredict_cnt = mispredict_cnt_q;
endmodule
